// File: rtl/cache_arbiter_if.sv
// Cache-side and physical-memory-side signals of the I/D cache line-fill arbiter.
// master: arbiter view; slave: caches plus memory view.
interface cache_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
);
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// I/D cache arbiter onto one pmem port: strobe 1 cycle after request, resp 1 cycle after pmem_resp;
// requests wait while the single outstanding pmem transaction runs. ARB_ROUND_ROBIN_EN selects round-robin ties.
module cache_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input logic             clk,
   input logic             rst,
   cache_arbiter_if.master bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } pmem_req_t;

   logic [1:0]        state_q,   state_d;
   pmem_req_t         req_q,     req_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_resp_q,  i_resp_d;
   logic              d_resp_q,  d_resp_d;

   logic i_req;
   logic d_req;
   logic tie_to_d;
   logic grant_d;

   assign i_req   = bus.i_read;
   assign d_req   = bus.d_read | bus.d_write;
   assign grant_d = d_req & (~i_req | tie_to_d);

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers the side granted last; resets to D so the first tie goes to I.
   logic last_d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_q <= 1'b1;
      end else if (state_q == IDLE && (i_req || d_req)) begin
         last_d_q <= grant_d;
      end
   end

   assign tie_to_d = ~last_d_q;
`else
   assign tie_to_d = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_resp_d  = 1'b0;
      d_resp_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               // A simultaneous read and write is a writeback; the read is dropped.
               req_d.rd    = bus.d_read & ~bus.d_write;
               req_d.wr    = bus.d_write;
               req_d.addr  = bus.d_address;
               req_d.wdata = bus.d_wdata;
               state_d     = SERVE_D;
            end else if (i_req) begin
               req_d.rd    = 1'b1;
               req_d.wr    = 1'b0;
               req_d.addr  = bus.i_address;
               req_d.wdata = '0;
               state_d     = SERVE_I;
            end
         end
         SERVE_I: begin
            if (bus.pmem_resp) begin
               i_rdata_d = bus.pmem_rdata;
               req_d.rd  = 1'b0;
               req_d.wr  = 1'b0;
               i_resp_d  = 1'b1;
               state_d   = RESP;
            end
         end
         SERVE_D: begin
            if (bus.pmem_resp) begin
               d_rdata_d = bus.pmem_rdata;
               req_d.rd  = 1'b0;
               req_d.wr  = 1'b0;
               d_resp_d  = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            // One idle cycle lets the retired requester drop its request first.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_resp_q  <= 1'b0;
         d_resp_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_resp_q  <= i_resp_d;
         d_resp_q  <= d_resp_d;
      end
   end

   assign bus.pmem_read    = req_q.rd;
   assign bus.pmem_write   = req_q.wr;
   assign bus.pmem_address = req_q.addr;
   assign bus.pmem_wdata   = req_q.wdata;
   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_rdata      = d_rdata_q;
   assign bus.i_resp       = i_resp_q;
   assign bus.d_resp       = d_resp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-side fills/writebacks, ties, stray pmem_resp, mid-transaction reset.
module tb_cache_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   chk = 0;
   int   err = 0;
   int   i_cnt = 0;
   int   d_cnt = 0;
   int   viol = 0;

   cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

   cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.i_resp) i_cnt++;
         if (bus.d_resp) d_cnt++;
         if (bus.pmem_read && bus.pmem_write) viol++;
         if (bus.i_resp && bus.d_resp) viol++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobe(output bit found);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.pmem_read || bus.pmem_write) begin
            found = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic pulse_resp(input logic [LINE_W-1:0] data);
      bus.pmem_rdata = data;
      bus.pmem_resp  = 1'b1;
      tick();
      bus.pmem_resp  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk++; if (bus.pmem_read !== 1'b0) begin err++; $display("FAIL reset_pmem_read: got %b want 0", bus.pmem_read); end
      chk++; if (bus.pmem_write !== 1'b0) begin err++; $display("FAIL reset_pmem_write: got %b want 0", bus.pmem_write); end
      chk++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin err++; $display("FAIL reset_resp: got %b want 00", {bus.i_resp, bus.d_resp}); end
      chk++; if (bus.pmem_address !== '0) begin err++; $display("FAIL reset_addr: got %h want 0", bus.pmem_address); end
      chk++; if (bus.pmem_wdata !== '0) begin err++; $display("FAIL reset_wdata: got %h want 0", bus.pmem_wdata); end
      chk++; if ({bus.i_rdata, bus.d_rdata} !== '0) begin err++; $display("FAIL reset_rdata: got %h %h want 0", bus.i_rdata, bus.d_rdata); end
   endtask

   task automatic test_i_read();
      logic [LINE_W-1:0] a5 = {32{8'hA5}};
      int ib = i_cnt;
      int db = d_cnt;
      bus.i_address = 32'h0000_0100;
      bus.i_read    = 1'b1;
      tick();
      chk++; if (bus.pmem_read !== 1'b1) begin err++; $display("FAIL i_strobe_n1: got %b want 1", bus.pmem_read); end
      chk++; if (bus.pmem_write !== 1'b0) begin err++; $display("FAIL i_no_write: got %b want 0", bus.pmem_write); end
      chk++; if (bus.pmem_address !== 32'h100) begin err++; $display("FAIL i_addr: got %h want 00000100", bus.pmem_address); end
      tick(); tick(); tick();
      chk++; if (bus.pmem_read !== 1'b1 || bus.i_resp !== 1'b0) begin err++; $display("FAIL i_held: got rd=%b resp=%b want 1 0", bus.pmem_read, bus.i_resp); end
      pulse_resp(a5);
      chk++; if (bus.i_resp !== 1'b1) begin err++; $display("FAIL i_resp: got %b want 1", bus.i_resp); end
      chk++; if (bus.i_rdata !== a5) begin err++; $display("FAIL i_rdata: got %h want %h", bus.i_rdata, a5); end
      chk++; if (bus.pmem_read !== 1'b0) begin err++; $display("FAIL i_strobe_drop: got %b want 0", bus.pmem_read); end
      bus.i_read = 1'b0;
      tick();
      chk++; if (bus.i_resp !== 1'b0) begin err++; $display("FAIL i_resp_pulse: got %b want 0", bus.i_resp); end
      tick();
      chk++; if (i_cnt - ib !== 1) begin err++; $display("FAIL i_resp_count: got %0d want 1", i_cnt - ib); end
      chk++; if (d_cnt - db !== 0) begin err++; $display("FAIL i_no_d_resp: got %0d want 0", d_cnt - db); end
   endtask

   task automatic test_stray_resp();
      pulse_resp({32{8'h5A}});
      chk++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin err++; $display("FAIL stray_resp: got %b want 00", {bus.i_resp, bus.d_resp}); end
      chk++; if (bus.i_rdata !== {32{8'hA5}}) begin err++; $display("FAIL stray_rdata_hold: got %h want a5..a5", bus.i_rdata); end
      tick();
      chk++; if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin err++; $display("FAIL stray_quiet: got %b want 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}); end
   endtask

   task automatic test_d_write();
      logic [LINE_W-1:0] w = {8{32'h1234_5678}};
      bus.d_address = 32'h0000_2040;
      bus.d_wdata   = w;
      bus.d_write   = 1'b1;
      tick();
      chk++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin err++; $display("FAIL dw_strobe: got wr/rd=%b want 10", {bus.pmem_write, bus.pmem_read}); end
      chk++; if (bus.pmem_address !== 32'h2040) begin err++; $display("FAIL dw_addr: got %h want 00002040", bus.pmem_address); end
      chk++; if (bus.pmem_wdata !== w) begin err++; $display("FAIL dw_wdata: got %h want %h", bus.pmem_wdata, w); end
      bus.d_address = 32'hFFFF_0000;
      bus.d_wdata   = '0;
      tick();
      chk++; if (bus.pmem_address !== 32'h2040 || bus.pmem_wdata !== w) begin err++; $display("FAIL dw_stable: got %h want 00002040 with held data", bus.pmem_address); end
      pulse_resp('0);
      chk++; if ({bus.d_resp, bus.i_resp, bus.pmem_write} !== 3'b100) begin err++; $display("FAIL dw_resp: got d/i/wr=%b want 100", {bus.d_resp, bus.i_resp, bus.pmem_write}); end
      bus.d_write = 1'b0;
      tick();
      chk++; if (bus.d_resp !== 1'b0) begin err++; $display("FAIL dw_resp_pulse: got %b want 0", bus.d_resp); end
      tick();
      chk++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin err++; $display("FAIL dw_no_regrant: got %b want 00", {bus.pmem_read, bus.pmem_write}); end
   endtask

   task automatic test_rw_both();
      bus.d_address = 32'h0000_3000;
      bus.d_wdata   = {16{16'hBEEF}};
      bus.d_read    = 1'b1;
      bus.d_write   = 1'b1;
      tick();
      chk++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin err++; $display("FAIL rw_writeback: got wr/rd=%b want 10", {bus.pmem_write, bus.pmem_read}); end
      pulse_resp('0);
      chk++; if (bus.d_resp !== 1'b1) begin err++; $display("FAIL rw_resp: got %b want 1", bus.d_resp); end
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      tick(); tick();
   endtask

   task automatic test_contention();
      bit found;
      logic first_d = !RR;
      logic [LINE_W-1:0] d1 = {32{8'h11}};
      logic [LINE_W-1:0] d2 = {32{8'h22}};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_address = 32'h0000_1000;
      bus.d_address = 32'h0000_2000;
      bus.d_wdata   = '0;
      bus.i_read    = 1'b1;
      bus.d_read    = 1'b1;
      wait_strobe(found);
      chk++; if (!found) begin err++; $display("FAIL tie_first_timeout: no strobe within bound"); end
      chk++; if (bus.pmem_address !== (first_d ? 32'h2000 : 32'h1000)) begin err++; $display("FAIL tie_first_addr: got %h want %h", bus.pmem_address, first_d ? 32'h2000 : 32'h1000); end
      pulse_resp(d1);
      chk++; if ({bus.d_resp, bus.i_resp} !== (first_d ? 2'b10 : 2'b01)) begin err++; $display("FAIL tie_first_resp: got d/i=%b want %b", {bus.d_resp, bus.i_resp}, first_d ? 2'b10 : 2'b01); end
      chk++; if ((first_d ? bus.d_rdata : bus.i_rdata) !== d1) begin err++; $display("FAIL tie_first_rdata: got %h want %h", first_d ? bus.d_rdata : bus.i_rdata, d1); end
      if (first_d) bus.d_read = 1'b0; else bus.i_read = 1'b0;
      wait_strobe(found);
      chk++; if (!found) begin err++; $display("FAIL tie_second_timeout: no strobe within bound"); end
      chk++; if (bus.pmem_address !== (first_d ? 32'h1000 : 32'h2000)) begin err++; $display("FAIL tie_second_addr: got %h want %h", bus.pmem_address, first_d ? 32'h1000 : 32'h2000); end
      pulse_resp(d2);
      chk++; if ({bus.d_resp, bus.i_resp} !== (first_d ? 2'b01 : 2'b10)) begin err++; $display("FAIL tie_second_resp: got d/i=%b want %b", {bus.d_resp, bus.i_resp}, first_d ? 2'b01 : 2'b10); end
      chk++; if ((first_d ? bus.i_rdata : bus.d_rdata) !== d2) begin err++; $display("FAIL tie_second_rdata: got %h want %h", first_d ? bus.i_rdata : bus.d_rdata, d2); end
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      bit found;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      // Both requests stay up: round-robin alternates I,D,I,D; fixed priority keeps picking D.
      for (int k = 0; k < 4; k++) begin
         logic exp_d = RR ? (k % 2 == 1) : 1'b1;
         logic [7:0] b = 8'h40 + 8'(k);
         logic [LINE_W-1:0] data = {32{b}};
         wait_strobe(found);
         chk++; if (!found) begin err++; $display("FAIL b2b_timeout_%0d: no strobe within bound", k); end
         chk++; if (bus.pmem_address !== (exp_d ? 32'h2000 : 32'h1000)) begin err++; $display("FAIL b2b_addr_%0d: got %h want %h", k, bus.pmem_address, exp_d ? 32'h2000 : 32'h1000); end
         pulse_resp(data);
         chk++; if ({bus.d_resp, bus.i_resp} !== (exp_d ? 2'b10 : 2'b01)) begin err++; $display("FAIL b2b_resp_%0d: got d/i=%b want %b", k, {bus.d_resp, bus.i_resp}, exp_d ? 2'b10 : 2'b01); end
         chk++; if ((exp_d ? bus.d_rdata : bus.i_rdata) !== data) begin err++; $display("FAIL b2b_rdata_%0d: got %h want %h", k, exp_d ? bus.d_rdata : bus.i_rdata, data); end
      end
      bus.d_read = 1'b0;
      if (!RR) begin
         wait_strobe(found);
         pulse_resp('0);
      end
      bus.i_read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      int db;
      bus.d_address = 32'h0000_4000;
      bus.d_read    = 1'b1;
      tick();
      chk++; if (bus.pmem_read !== 1'b1) begin err++; $display("FAIL rm_strobe: got %b want 1", bus.pmem_read); end
      tick();
      db = d_cnt;
      rst = 1'b1;
      bus.d_read = 1'b0;
      tick();
      rst = 1'b0;
      chk++; if ({bus.pmem_read, bus.pmem_write, bus.d_resp} !== 3'b000) begin err++; $display("FAIL rm_quiet: got rd/wr/resp=%b want 000", {bus.pmem_read, bus.pmem_write, bus.d_resp}); end
      chk++; if (bus.pmem_address !== '0 || bus.d_rdata !== '0) begin err++; $display("FAIL rm_cleared: got addr=%h want 0", bus.pmem_address); end
      tick();
      pulse_resp({32{8'hCC}});
      chk++; if (bus.d_resp !== 1'b0 || bus.d_rdata !== '0) begin err++; $display("FAIL rm_late_resp: got resp=%b rdata=%h want 0 0", bus.d_resp, bus.d_rdata); end
      tick();
      chk++; if (d_cnt - db !== 0) begin err++; $display("FAIL rm_no_resp: got %0d pulses want 0", d_cnt - db); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time bound");
      $fatal(1);
   end

   initial begin
      bus.i_read     = 1'b0;
      bus.i_address  = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_address  = '0;
      bus.d_wdata    = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
      tick();
      test_reset();
      test_i_read();
      test_stray_resp();
      test_d_write();
      test_rw_both();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      chk++; if (viol !== 0) begin err++; $display("FAIL exclusive_strobes_resps: got %0d overlaps want 0", viol); end
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
